fetch_decode_queue: RTL
=======================

# fetch_decode_queue

Small FIFO between the fetch stage and decode. It accepts one `{pc, instruction}` pair per cycle from fetch and discards fetch's bubble word. It holds up to `DEPTH` entries and presents the oldest to decode under a valid/ready handshake. A `flush` input empties it in one cycle on branch/jump redirects.

## Interface
- `ADDR_WIDTH`, 64, width of PC fields
- `INSTR_WIDTH`, 32, instruction width
- `DEPTH`, 4, entry count; power of two, ≥ 2
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `flush`  in  1  discard all entries and any same-cycle enqueue
- `in_valid`  in  1  fetch offers an entry
- `in_instruction`  in  INSTR_WIDTH  fetched word; bubble = 32'd90
- `in_pc`  in  ADDR_WIDTH  PC of `in_instruction`
- `in_ready`  out  1  queue can accept (count < DEPTH)
- `out_valid`  out  1  head entry present
- `out_instruction`  out  INSTR_WIDTH  head instruction; 32'd90 when empty
- `out_pc`  out  ADDR_WIDTH  head PC; 0 when empty
- `out_ready`  in  1  decode consumes head this cycle
- `count`  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Enqueue condition:
  - `in_valid && in_ready && !flush && in_instruction != BUBBLE`.
  - Bubble words are accepted (handshake completes) but not stored.
- Dequeue condition: `out_valid && out_ready && !flush`.
- Ready and valid:
  - `in_ready = (count != DEPTH)`, from registered count only; no same-cycle pass-through when full.
  - `out_valid = (count != 0)`.
- Pointers:
  - `wr_ptr`/`rd_ptr` are `$clog2(DEPTH)` bits and wrap modulo `DEPTH` naturally.
  - `count` update per cycle: +1 on enqueue only, −1 on dequeue only, unchanged on both or neither.
- Simultaneous enqueue+dequeue (0 < count < DEPTH): both pointers advance, count unchanged.
- Output data:
  - `out_instruction`/`out_pc` are read combinationally from the head slot when `out_valid`.
  - When empty, outputs are forced to 32'd90 / 0.
- Flush:
  - Next cycle: `wr_ptr = rd_ptr = 0`, `count = 0`.
  - The same-cycle enqueue and dequeue are suppressed.
  - Flush has priority over every other event.
- Reset has priority over flush. Reset values:
  - `count = 0`, `wr_ptr = rd_ptr = 0`.
  - `out_valid = 0`, `out_instruction = 32'd90`, `out_pc = 0`.
  - `in_ready = 1`.
- Storage contents need no reset.
- Decode may hold `out_ready` low indefinitely; the head stays stable while `out_valid && !out_ready && !flush`.

## Timing
- Latency: an entry enqueued at edge N is visible on `out_*` after edge N (earliest consume cycle N+1). There is no combinational in→out path.
- Throughput: one enqueue and one dequeue per cycle sustained.
- `in_ready` deasserts the cycle after the queue becomes full. It reasserts the cycle after the first dequeue from full.
- After a flush at edge N: `out_valid = 0` and `in_ready = 1` from edge N until new enqueues.
- Reset mid-operation: all entries are lost at the reset edge. Outputs take reset values the following cycle.

## Structure
- Shared pipeline package holds:
  - `BUBBLE_INSTR` = 32'd90, shared with the fetch stage.
  - `fetch_entry_t` packed struct `{pc, instruction}`.
- Storage is a `fetch_entry_t` array `[DEPTH]`, written on enqueue.
- No sub-module; pointer/count logic plus the array stays inline, one always_ff and one always_comb.

## Test plan
- Reset, then push pcs 0x100/0x104/0x108 with out_ready=0 → count=3; out_pc=0x100 held; out_instruction = first word.
- Fill DEPTH=4 and offer a 5th (pc 0x110) → in_ready=0 the cycle after the 4th enqueue. 5th not stored. Pop one → in_ready=1 next cycle and 0x110 accepted.
- in_instruction=32'd90 with in_valid=1 for 3 cycles into an empty queue → in_ready stays 1, count stays 0, out_valid=0.
- count=2, enqueue and dequeue same cycle for 10 cycles with incrementing PCs → count stays 2. out_pc sequence is strictly in order across pointer wrap.
- count=3, assert flush together with in_valid (pc 0x200) and out_ready → next cycle count=0, out_valid=0, out_pc=0. 0x200 is not present afterwards.
- count=2, assert reset with in_valid=1 → next cycle count=0, out_instruction=32'd90, in_ready=1. The first push after reset appears at head.

Source files
------------

// File: rtl/fetch_decode_queue_pkg.sv
// Shared fetch/decode pipeline definitions: the bubble word fetch emits and
// the {pc, instruction} entry layout carried between the two stages.
package fetch_decode_queue_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] BUBBLE_INSTR = 32'd90;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode FIFO: drops fetch bubbles, presents the oldest entry to
// decode under valid/ready, and empties in one cycle on a redirect flush.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [INSTR_WIDTH-1:0]   in_instruction,
  input  logic [ADDR_WIDTH-1:0]    in_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [INSTR_WIDTH-1:0]   out_instruction,
  output logic [ADDR_WIDTH-1:0]    out_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             enq;
  logic             deq;

  // Handshake and head read are pure functions of registered state, so no
  // input ever reaches the outputs in the same cycle.
  always_comb begin
    in_ready        = (count_q != FULL_CNT);
    out_valid       = (count_q != '0);
    enq             = in_valid && in_ready && !flush &&
                      (in_instruction != BUBBLE_INSTR);
    deq             = out_valid && out_ready && !flush;
    out_instruction = BUBBLE_INSTR;
    out_pc          = '0;
    if (out_valid) begin
      out_instruction = mem[rd_ptr].instruction;
      out_pc          = mem[rd_ptr].pc;
    end
  end

  assign count = count_q;

  // Storage is written without reset; only pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= '{pc: in_pc, instruction: in_instruction};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (enq && !deq) begin
        count_q <= count_q + 1'b1;
      end else if (deq && !enq) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule
